cla_serial_adder: RTL
=====================

Name: cla_serial_adder

Overview:
- Multi-cycle, nibble-serial adder of WIDTH-bit operands built around one `cla_4bit` instance.
- Sits directly upstream of `cla_4bit`: slices operands into 4-bit chunks and feeds them one nibble per cycle, LSB first.
- Carries Cout of each nibble back into Cin of the next.
- Wide additions reuse the existing 4-bit CLA with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
- NIBBLES (localparam), WIDTH/4, number of RUN cycles per operation.
- CNT_W (localparam), $clog2(NIBBLES) (min 1), nibble counter width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A, sampled on acceptance.
- B  input  WIDTH  operand B, sampled on acceptance.
- Cin  input  1  carry-in, sampled on acceptance.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream consumes result.
- Sum  output  WIDTH  A+B+Cin mod 2^WIDTH.
- Cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high; it takes effect only on a rising clk edge.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, Sum=0, Cout=0.
  - Internal shift registers, carry register and counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance = in_valid && in_ready at a rising edge.
  - On acceptance: latch A->a_sh, B->b_sh, Cin->c_reg; cnt=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - cla_4bit inputs: a_sh[3:0], b_sh[3:0], c_reg.
  - Each edge:
    - a_sh, b_sh shift right by 4.
    - s_sh <= {nibble_sum, s_sh[WIDTH-1:4]}.
    - c_reg <= nibble Cout.
    - cnt++.
  - When cnt==NIBBLES-1 at an edge: transfer the final s_sh and carry into Sum/Cout; go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - Sum/Cout held stable until out_valid && out_ready at an edge, then go to IDLE.
  - Sum/Cout keep their last value after the handshake; they are valid only while out_valid=1.
- Latency:
  - Acceptance at edge k; out_valid is high after edge k+NIBBLES.
  - With out_ready=1, the next acceptance is possible at edge k+NIBBLES+2 (one IDLE cycle).
  - Throughput: 1 op per NIBBLES+2 cycles.
- Boundaries:
  - WIDTH=4: RUN lasts exactly 1 cycle.
  - Full carry ripple across all nibbles must be correct (e.g. all-ones + Cin=1).
  - in_valid during RUN/DONE is ignored and not queued.
  - out_ready while out_valid=0 has no effect.
  - Operand inputs may change freely after acceptance without affecting the result.
  - rst asserted in RUN or DONE aborts the operation: all outputs return to reset values at that edge, no result is produced, and the FSM is in IDLE the next cycle.
  - rst has priority over every handshake in the same cycle.

Optional Feature:
- Macro: CLA_SERIAL_OVF_EN.
- Defined:
  - Adds output port Ovf (1 bit) = signed two's-complement overflow.
  - Ovf = carry into MSB XOR carry out of MSB, computed during the final nibble.
  - Registered with Sum; reset 0; held in DONE like Sum.
- Undefined: port Ovf absent; no extra logic.

Test Plan:
- Reset then idle (WIDTH=16): after rst, in_ready=1, out_valid=0, Sum=16'h0000, Cout=0; holding in_valid=0 for 10 cycles keeps these values.
- Basic add: A=16'h0001, B=16'h0002, Cin=0 -> out_valid exactly 4 cycles after acceptance, Sum=16'h0003, Cout=0.
- Full carry ripple: A=16'hFFFF, B=16'h0001, Cin=0 -> Sum=16'h0000, Cout=1; A=16'hFFFF, B=16'hFFFF, Cin=1 -> Sum=16'hFFFF, Cout=1.
- Backpressure: A=16'hA5A5, B=16'h5A5A, Cin=1 with out_ready=0 for 5 cycles -> out_valid stays 1 and Sum=16'h0000, Cout=1 held stable; in_valid pulses meanwhile are ignored; out_ready=1 returns the FSM to IDLE.
- Reset mid-operation: accept A=16'h1234, B=16'h1111; assert rst at RUN cycle 2 -> out_valid never rises, Sum=0, in_ready=1 the next cycle; a following A=16'h0F0F, B=16'h00F1 gives Sum=16'h1000, Cout=0.
- Overflow, with CLA_SERIAL_OVF_EN defined:
  - A=16'h7FFF, B=16'h0001 -> Sum=16'h8000, Ovf=1, Cout=0.
  - A=16'h8000, B=16'hFFFF -> Sum=16'h7FFF, Ovf=1, Cout=1.

Source files
------------

// File: rtl/cla_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_serial_adder (with helper cla_4bit)
// Description : Nibble-serial WIDTH-bit adder. Operands are accepted with a
//               valid/ready handshake, added one nibble per cycle (LSB first)
//               through a single 4-bit carry-lookahead adder, and presented
//               with a valid/ready handshake on the output side.
//               Optional feature macro: CLA_SERIAL_OVF_EN adds output Ovf,
//               the signed two's-complement overflow of the addition.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// cla_4bit: single-level 4-bit carry-lookahead adder (pure combinational)
// ----------------------------------------------------------------------------
module cla_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);

   logic [3:0] p_w;
   logic [3:0] g_w;
   logic [4:0] c_w;

   // Propagate/generate terms and fully flattened lookahead carries
   always_comb begin
      p_w = a_i ^ b_i;
      g_w = a_i & b_i;
      c_w[0] = cin_i;
      c_w[1] = g_w[0] | (p_w[0] & cin_i);
      c_w[2] = g_w[1] | (p_w[1] & g_w[0]) | (p_w[1] & p_w[0] & cin_i);
      c_w[3] = g_w[2] | (p_w[2] & g_w[1]) | (p_w[2] & p_w[1] & g_w[0])
             | (p_w[2] & p_w[1] & p_w[0] & cin_i);
      c_w[4] = g_w[3] | (p_w[3] & g_w[2]) | (p_w[3] & p_w[2] & g_w[1])
             | (p_w[3] & p_w[2] & p_w[1] & g_w[0])
             | (p_w[3] & p_w[2] & p_w[1] & p_w[0] & cin_i);
      sum_o  = p_w ^ c_w[3:0];
      cout_o = c_w[4];
   end

endmodule

// ----------------------------------------------------------------------------
// cla_serial_adder: top level
// ----------------------------------------------------------------------------
module cla_serial_adder #(
   parameter int WIDTH = 16   // multiple of 4, >= 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef CLA_SERIAL_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  a_sh_q;
   logic [WIDTH-1:0]  b_sh_q;
   logic [WIDTH-1:0]  s_sh_q;
   logic              c_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [WIDTH-1:0]  sum_q;
   logic              cout_q;

   logic [3:0]        nib_sum_w;
   logic              nib_cout_w;
   logic [WIDTH-1:0]  s_sh_d;

   // The CLA always sees the low nibble of the shift registers and the
   // running carry; its result is only consumed while in RUN.
   cla_4bit u_cla (
      .a_i    (a_sh_q[3:0]),
      .b_i    (b_sh_q[3:0]),
      .cin_i  (c_q),
      .sum_o  (nib_sum_w),
      .cout_o (nib_cout_w)
   );

   // Next sum shift value: new nibble enters at the top, older ones move down.
   // A single-nibble adder has nothing to shift, so it is handled separately.
   generate
      if (NIBBLES == 1) begin : g_single_nibble
         assign s_sh_d = nib_sum_w;
      end else begin : g_multi_nibble
         assign s_sh_d = {nib_sum_w, s_sh_q[WIDTH-1:4]};
      end
   endgenerate

`ifdef CLA_SERIAL_OVF_EN
   logic ovf_q;
   logic ovf_d;
   // Carry into the MSB is recovered from the MSB sum bit of the final nibble
   always_comb begin
      ovf_d = (a_sh_q[3] ^ b_sh_q[3] ^ nib_sum_w[3]) ^ nib_cout_w;
   end
`endif

   // Control FSM and datapath registers; reset overrides every handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         s_sh_q      <= '0;
         c_q         <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_sh_q     <= A;
                  b_sh_q     <= B;
                  c_q        <= Cin;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sh_q <= a_sh_q >> 4;
               b_sh_q <= b_sh_q >> 4;
               s_sh_q <= s_sh_d;
               c_q    <= nib_cout_w;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  sum_q       <= s_sh_d;
                  cout_q      <= nib_cout_w;
`ifdef CLA_SERIAL_OVF_EN
                  ovf_q       <= ovf_d;
`endif
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Result outputs hold; they are simply not refreshed here
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Sum       = sum_q;
   assign Cout      = cout_q;
`ifdef CLA_SERIAL_OVF_EN
   assign Ovf       = ovf_q;
`endif

endmodule
`default_nettype wire
